// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver-core side and host-side byte consumer signals of uart_rx_ctrl
interface uart_rx_ctrl_if #(parameter int DBIT = 8, parameter int FIFO_AW = 2);
    logic rx_out, s_tick, rx_done_tick;
    logic [DBIT-1:0] rx_dout;
    logic rd, clr_err, rx_empty, rx_full, overrun, frame_err;
    logic [7:0] r_data;
    logic [FIFO_AW:0] count;
    modport master(
        output rx_out, s_tick, r_data, rx_empty, rx_full, count, overrun, frame_err,
        input rx_done_tick, rx_dout, rd, clr_err
    );
    modport slave(
        input rx_out, s_tick, r_data, rx_empty, rx_full, count, overrun, frame_err,
        output rx_done_tick, rx_dout, rd, clr_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: rx line synchroniser, 16x tick generator and FWFT byte FIFO with sticky error flags
module uart_rx_ctrl #(
    parameter int DBIT = 8,
    parameter int DVSR_W = 11,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx_in,
    uart_rx_ctrl_if.master    bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    logic sync1, rx_sync, tick, push, pop, wr, full, empty, ovr, fe;
    logic [DVSR_W-1:0] cnt;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] occ;
    logic [DBIT-1:0] din;
    logic [7:0] mem [DEPTH];
    assign din = bus.rx_dout;
    // >= rather than == so a divisor lowered below the running count fires at once
    assign tick = cnt >= dvsr;
    assign full = occ == (FIFO_AW+1)'(DEPTH);
    assign empty = occ == '0;
    assign push = bus.rx_done_tick & en;
    assign pop = bus.rd & ~empty;
    // a full FIFO accepts the push only when the same cycle frees a slot
    assign wr = push & (~full | pop);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync1 <= 1'b1;
            rx_sync <= 1'b1;
            cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
            ovr <= 1'b0;
            fe <= 1'b0;
        end else begin
            sync1 <= rx_in;
            rx_sync <= sync1;
            cnt <= en ? (tick ? '0 : cnt + 1'b1) : '0;
            wr_ptr <= wr_ptr + FIFO_AW'(wr);
            rd_ptr <= rd_ptr + FIFO_AW'(pop);
            occ <= occ + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
            ovr <= (push & full & ~pop) | (ovr & ~bus.clr_err);
            fe <= (push & ~rx_sync) | (fe & ~bus.clr_err);
        end
    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din[7:0];
    assign bus.rx_out = en ? rx_sync : 1'b1;
    assign bus.s_tick = en & tick;
    assign bus.r_data = empty ? 8'h00 : mem[rd_ptr];
    assign bus.rx_empty = empty;
    assign bus.rx_full = full;
    assign bus.count = occ;
    assign bus.overrun = ovr;
    assign bus.frame_err = fe;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: vector table plus byte scoreboard for uart_rx_ctrl
module tb_uart_rx_ctrl;
    logic clk = 1'b0, reset_n = 1'b0, en = 1'b1, rx_in = 1'b1;
    logic [10:0] dvsr = 11'd3;
    int tests = 0, failed = 0;
    logic [7:0] q[$];
    uart_rx_ctrl_if #(.DBIT(8), .FIFO_AW(2)) bus();
    uart_rx_ctrl #(.DBIT(8), .DVSR_W(11), .FIFO_AW(2)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .dvsr(dvsr), .rx_in(rx_in), .bus(bus.master)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic en, done;
        logic [7:0] dout;
        logic rd, clr;
        int cnt;
        logic ovr;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic e, input logic d, input logic [7:0] dv, input logic r, input logic c);
        logic p;
        en = e;
        bus.rx_done_tick = d;
        bus.rx_dout = dv;
        bus.rd = r;
        bus.clr_err = c;
        p = r && q.size() > 0;
        if (p) begin
            chk("pop_data", 32'(bus.r_data), 32'(q[0]));
            void'(q.pop_front());
        end
        if (d && e && (q.size() < 4 || p)) q.push_back(dv);
        tick();
        bus.rx_done_tick = 1'b0;
        bus.rd = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        bus.rx_done_tick = 1'b0;
        bus.rx_dout = 8'h00;
        bus.rd = 1'b0;
        bus.clr_err = 1'b0;
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 4, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 4, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 4, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0};

        // reset state, tick cadence with dvsr = 3, synchroniser latency
        tick();
        tick();
        chk("rst_empty", 32'(bus.rx_empty), 1);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_rdata", 32'(bus.r_data), 0);
        chk("rst_rx_out", 32'(bus.rx_out), 1);
        chk("rst_s_tick", 32'(bus.s_tick), 0);
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("tick_%0d", i), 32'(bus.s_tick), 32'(i % 4 == 3));
        end
        rx_in = 1'b0;
        tick();
        chk("sync_lat1", 32'(bus.rx_out), 1);
        tick();
        chk("sync_lat2", 32'(bus.rx_out), 0);
        rx_in = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].en, tbl[i].done, tbl[i].dout, tbl[i].rd, tbl[i].clr);
            chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_ovr", i), 32'(bus.overrun), 32'(tbl[i].ovr));
            chk($sformatf("v%0d_empty", i), 32'(bus.rx_empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("v%0d_full", i), 32'(bus.rx_full), 32'(tbl[i].cnt == 4));
            chk($sformatf("v%0d_head", i), 32'(bus.r_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
        end

        // framing error and set-beats-clear
        rx_in = 1'b0;
        tick();
        tick();
        chk("fe_rx_out_low", 32'(bus.rx_out), 0);
        cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fe_set", 32'(bus.frame_err), 1);
        chk("fe_head", 32'(bus.r_data), 32'h5A);
        cyc(1'b1, 1'b1, 8'h5B, 1'b0, 1'b1);
        chk("fe_set_wins", 32'(bus.frame_err), 1);
        en = 1'b0;
        #1;
        chk("dis_rx_out_idle", 32'(bus.rx_out), 1);
        en = 1'b1;
        rx_in = 1'b1;
        tick();
        tick();
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("fe_clr", 32'(bus.frame_err), 0);
        chk("fe_count", 32'(bus.count), 2);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fe_drained", 32'(bus.rx_empty), 1);

        // divisor change below the running count, disable and re-enable
        dvsr = 11'd100;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n += int'(bus.s_tick);
        end
        chk("no_tick_to_50", n, 0);
        dvsr = 11'd2;
        #1;
        chk("dvsr_drop_tick", 32'(bus.s_tick), 1);
        tick();
        chk("dvsr_drop_wrap", 32'(bus.s_tick), 0);
        dvsr = 11'd100;
        for (int i = 0; i < 50; i++) tick();
        en = 1'b0;
        dvsr = 11'd2;
        #1;
        n = int'(bus.s_tick);
        cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        n += int'(bus.s_tick);
        for (int i = 0; i < 4; i++) begin
            tick();
            n += int'(bus.s_tick);
        end
        chk("dis_no_tick", n, 0);
        chk("dis_no_push", 32'(bus.count), 0);
        en = 1'b1;
        #1;
        seen = bus.s_tick;
        for (int i = 0; i < 3 && !seen; i++) begin
            tick();
            seen = bus.s_tick;
        end
        chk("reen_tick_3", 32'(seen), 1);

        // asynchronous reset mid-frame with data and a flag pending
        dvsr = 11'd5;
        cyc(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        rx_in = 1'b0;
        tick();
        tick();
        cyc(1'b1, 1'b1, 8'h96, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 2);
        chk("pre_rst_fe", 32'(bus.frame_err), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_empty", 32'(bus.rx_empty), 1);
        chk("arst_full", 32'(bus.rx_full), 0);
        chk("arst_rdata", 32'(bus.r_data), 0);
        chk("arst_fe", 32'(bus.frame_err), 0);
        chk("arst_ovr", 32'(bus.overrun), 0);
        chk("arst_rx_out", 32'(bus.rx_out), 1);
        chk("arst_s_tick", 32'(bus.s_tick), 0);
        q.delete();
        tick();
        reset_n = 1'b1;
        rx_in = 1'b1;
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_rd_empty", 32'(bus.count), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
